truth_table_bist: RTL and testbench



---
 rtl/truth_table_bist_pkg.sv | 15 +
 rtl/truth_table_bist_if.sv | 24 ++
 rtl/truth_table_bist_settle_counter.sv | 32 +++
 rtl/truth_table_bist.sv | 117 +++++++++++
 tb/tb_truth_table_bist.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/truth_table_bist_pkg.sv
// Shared types and default constants for the truth-table BIST driver/checker.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        FINISH
    } bist_state_t;

    localparam int         BIST_WIDTH  = 3;
    localparam int         BIST_SETTLE = 4;
    localparam logic [7:0] BIST_EXPECT = 8'b0010_0100;

endpackage

// File: rtl/truth_table_bist_if.sv
// Control/result and DUT-facing signals of the truth-table BIST.
// The slave side is the BIST itself; the master side is the controller plus the DUT.
interface truth_table_bist_if #(
    parameter int WIDTH = 3
);
    logic             START;
    logic [WIDTH-1:0] STIM;
    logic             RESP;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic [WIDTH:0]   FAIL_COUNT;
    logic [WIDTH-1:0] FIRST_FAIL;

    modport slave (
        input  START, RESP,
        output STIM, BUSY, DONE, PASS, FAIL_COUNT, FIRST_FAIL
    );

    modport master (
        output START, RESP,
        input  STIM, BUSY, DONE, PASS, FAIL_COUNT, FIRST_FAIL
    );
endinterface

// File: rtl/truth_table_bist_settle_counter.sv
// Loadable down-counter timing how long each vector is held before sampling.
module bist_settle_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          tc
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == '0);
endmodule

// File: rtl/truth_table_bist.sv
// Sweeps all 2^WIDTH vectors onto a combinational DUT and checks RESP against EXPECT_MASK.
// Optional: define BIST_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module truth_table_bist
    import bist_pkg::*;
#(
    parameter int                  WIDTH         = BIST_WIDTH,
    parameter int                  SETTLE_CYCLES = BIST_SETTLE,
    parameter logic [2**WIDTH-1:0] EXPECT_MASK   = BIST_EXPECT
) (
    input logic               CLK,
    input logic               N_RESET,
    truth_table_bist_if.slave bus
);
    localparam int               CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WIDTH-1:0] LAST = '1;

    bist_state_t      state_q, state_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH:0]   fail_cnt_q, fail_cnt_d;
    logic [WIDTH-1:0] first_fail_q, first_fail_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic             cnt_clr, cnt_load, cnt_en, cnt_tc;
    logic             mism, stop_now;

    assign mism = (bus.RESP != EXPECT_MASK[idx_q]);

`ifdef BIST_STOP_ON_FAIL_EN
    assign stop_now = mism;
`else
    assign stop_now = 1'b0;
`endif

    bist_settle_counter #(.CW(CW)) u_settle (
        .clk      (CLK),
        .rst_n    (N_RESET),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (CW'(SETTLE_CYCLES - 1)),
        .en       (cnt_en),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        done_d       = 1'b0;
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    fail_cnt_d   = '0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                    idx_d        = '0;
                    cnt_load     = 1'b1;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                cnt_en = 1'b1;
                if (cnt_tc) state_d = CHECK;
            end
            CHECK: begin
                if (mism) begin
                    fail_cnt_d = fail_cnt_q + 1'b1;
                    if (fail_cnt_q == '0) first_fail_d = idx_q;
                end
                // Terminal test precedes the increment, so idx never wraps.
                if (idx_q == LAST || stop_now) begin
                    state_d = FINISH;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    cnt_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                pass_d  = (fail_cnt_q == '0);
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
        end
    end

    assign bus.STIM       = idx_q;
    assign bus.BUSY       = (state_q == SETTLE) || (state_q == CHECK);
    assign bus.DONE       = done_q;
    assign bus.PASS       = pass_q;
    assign bus.FAIL_COUNT = fail_cnt_q;
    assign bus.FIRST_FAIL = first_fail_q;
endmodule

// File: tb/tb_truth_table_bist.sv
// Randomized bench: three BIST instances (settle 4, 1, 3) against a truth-table reference model.
module tb_truth_table_bist;
    import bist_pkg::*;

    localparam int         W   = 3;
    localparam logic [7:0] EXP = BIST_EXPECT;

    logic       CLK = 1'b0;
    logic       N_RESET = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tt = EXP;
    logic [1:0] lag1 = '0;
    logic [1:0] lag3 = '0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         p1 = 0;

    always #5 CLK = ~CLK;

    truth_table_bist_if #(.WIDTH(W)) bus4 ();
    truth_table_bist_if #(.WIDTH(W)) bus1 ();
    truth_table_bist_if #(.WIDTH(W)) bus3 ();

    truth_table_bist #(.WIDTH(W), .SETTLE_CYCLES(4), .EXPECT_MASK(EXP)) dut (
        .CLK(CLK), .N_RESET(N_RESET), .bus(bus4.slave));
    truth_table_bist #(.WIDTH(W), .SETTLE_CYCLES(1), .EXPECT_MASK(EXP)) dut_s1 (
        .CLK(CLK), .N_RESET(N_RESET), .bus(bus1.slave));
    truth_table_bist #(.WIDTH(W), .SETTLE_CYCLES(3), .EXPECT_MASK(EXP)) dut_s3 (
        .CLK(CLK), .N_RESET(N_RESET), .bus(bus3.slave));

    assign bus4.START = start;
    assign bus1.START = start;
    assign bus3.START = start;

    // Modelled DUTs: main one is combinational, the other two respond two cycles late.
    assign bus4.RESP = tt[bus4.STIM];
    always @(posedge CLK) begin
        lag1 <= {lag1[0], tt[bus1.STIM]};
        lag3 <= {lag3[0], tt[bus3.STIM]};
    end
    assign bus1.RESP = lag1[1];
    assign bus3.RESP = lag3[1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected results from the per-vector responses the checker will observe.
    function automatic void model(input logic [7:0] obs, input int s, output int fc,
                                  output int ff, output int done_at, output int last);
        logic [7:0] m;
        m       = obs ^ EXP;
        fc      = $countones(m);
        ff      = 0;
        for (int k = 7; k >= 0; k--) if (m[k]) ff = k;
        done_at = 8 * (s + 1) + 1;
        last    = 7;
`ifdef BIST_STOP_ON_FAIL_EN
        if (fc != 0) begin
            fc      = 1;
            done_at = (ff + 1) * (s + 1) + 1;
            last    = ff;
        end
`endif
    endfunction

    task automatic run(input string name, input logic [7:0] t, input bit chk_lag,
                       input int repulse_at, input int reset_at);
        logic [7:0] obs1;
        int fc4, ff4, d4, l4, fc1, ff1, d1, l1, fc3, ff3, d3, l3;
        int done4, done1, done3, ndone4, es;
        tt = t;
        repeat (4) @(negedge CLK);
        obs1 = {t[6:0], t[p1]};
        model(t, 4, fc4, ff4, d4, l4);
        model(obs1, 1, fc1, ff1, d1, l1);
        model(t, 3, fc3, ff3, d3, l3);
        done4 = -1; done1 = -1; done3 = -1; ndone4 = 0;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        chk({name, " busy0"}, 32'(bus4.BUSY), 32'd1);
        for (int n = 1; n <= 60; n++) begin
            @(posedge CLK);
            #1;
            if (bus4.DONE) begin
                ndone4++;
                if (done4 < 0) done4 = n;
            end
            if (bus1.DONE && done1 < 0) done1 = n;
            if (bus3.DONE && done3 < 0) done3 = n;
            if ((reset_at < 0 || n < reset_at) && n < d4 && n % 5 == 2) begin
                es = (n / 5 < l4) ? n / 5 : l4;
                chk($sformatf("%s stim@%0d", name, n), 32'(bus4.STIM), 32'(es));
            end
            if (n == repulse_at - 1) start = 1'b1;
            if (n == repulse_at) start = 1'b0;
            if (n == reset_at) begin
                N_RESET = 1'b0;
                #1;
                chk({name, " rst outs"}, {bus4.STIM, bus4.BUSY, bus4.DONE, bus4.PASS,
                                          bus4.FAIL_COUNT, bus4.FIRST_FAIL}, 32'd0);
            end
        end
        if (reset_at >= 0) begin
            chk({name, " no done"}, 32'(ndone4), 32'd0);
            @(negedge CLK) N_RESET = 1'b1;
            p1 = 0;
        end else begin
            chk({name, " done@"}, 32'(done4), 32'(d4));
            chk({name, " done pulses"}, 32'(ndone4), 32'd1);
            chk({name, " pass"}, 32'(bus4.PASS), 32'(fc4 == 0));
            chk({name, " fail_count"}, 32'(bus4.FAIL_COUNT), 32'(fc4));
            chk({name, " first_fail"}, 32'(bus4.FIRST_FAIL), 32'(ff4));
            chk({name, " stim end"}, 32'(bus4.STIM), 32'(l4));
            chk({name, " busy end"}, 32'(bus4.BUSY), 32'd0);
            if (chk_lag) begin
                chk({name, " s1 done@"}, 32'(done1), 32'(d1));
                chk({name, " s1 fail_count"}, 32'(bus1.FAIL_COUNT), 32'(fc1));
                chk({name, " s1 first_fail"}, 32'(bus1.FIRST_FAIL), 32'(ff1));
                chk({name, " s1 pass"}, 32'(bus1.PASS), 32'(fc1 == 0));
                chk({name, " s3 done@"}, 32'(done3), 32'(d3));
                chk({name, " s3 fail_count"}, 32'(bus3.FAIL_COUNT), 32'(fc3));
                chk({name, " s3 pass"}, 32'(bus3.PASS), 32'(fc3 == 0));
                p1 = l1;
            end
        end
    endtask

    initial begin
        #12;
        chk("reset outs", {bus4.STIM, bus4.BUSY, bus4.DONE, bus4.PASS,
                           bus4.FAIL_COUNT, bus4.FIRST_FAIL}, 32'd0);
        @(negedge CLK) N_RESET = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle busy", 32'(bus4.BUSY), 32'd0);

        run("correct", EXP, 1'b1, -1, -1);
        run("stuck0", 8'h00, 1'b1, -1, -1);
        run("inverted", ~EXP, 1'b1, -1, -1);
        for (int i = 0; i < 6; i++)
            run($sformatf("rand%0d", i), 8'($urandom), 1'b1, -1, -1);
        run("restart20", EXP, 1'b0, 20, -1);
        run("reset22", EXP, 1'b0, -1, 22);
        run("after_rst", EXP, 1'b1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
